vehicle_status_monitor: RTL and testbench
=========================================

Name: vehicle_status_monitor

Overview:
Sensor-conditioning stage that feeds the safety-control logic. It converts raw temperature samples, fuel-level samples and wheel-tick odometry into three clean, registered, debounced status flags: cpu_overheated, gas_tank_empty and arrived. The downstream combinational safety logic consumes these flags directly, so no glitch or single-sample spike may reach it.

Parameters:
TEMP_W, 8, width of temperature sample (unsigned, degrees C)
TEMP_HI, 85, overheat set threshold (sample >= TEMP_HI qualifies)
TEMP_LO, 75, overheat clear threshold (sample <= TEMP_LO qualifies); must be < TEMP_HI
FUEL_W, 8, width of fuel-level sample (unsigned)
FUEL_EMPTY, 4, empty threshold (level <= FUEL_EMPTY is "low")
DEBOUNCE, 4, consecutive qualifying valid samples needed to change a flag; >= 1
DIST_W, 16, width of trip distance counter (wheel ticks)

Ports:
clk  input  1  single system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
temp_valid  input  1  temp_sample valid this cycle
temp_sample  input  TEMP_W  CPU temperature sample
fuel_valid  input  1  fuel_level valid this cycle
fuel_level  input  FUEL_W  fuel-level sample
trip_load  input  1  load new trip distance
trip_distance  input  DIST_W  ticks to destination, captured on trip_load
wheel_tick  input  1  one-cycle pulse per wheel tick travelled
cpu_overheated  output  1  debounced overheat flag, registered
gas_tank_empty  output  1  debounced empty-tank flag, registered
arrived  output  1  trip complete / no trip active, registered
dist_remaining  output  DIST_W  ticks left in current trip

Behaviour:
- Reset (async, rst_n=0): cpu_overheated=0, gas_tank_empty=1, arrived=1, dist_remaining=0, all debounce counters 0, temp FSM NORMAL, fuel FSM ALARM. The vehicle does not drive until a trip is loaded and fuel is confirmed.
- Temp FSM, two states NORMAL (flag 0) and ALARM (flag 1):
  - NORMAL: each temp_valid with sample >= TEMP_HI increments cnt. A valid sample below TEMP_HI clears cnt to 0.
  - When the DEBOUNCE-th consecutive qualifying sample is captured, go to ALARM and clear cnt. cpu_overheated=1 from the next cycle, so latency is 1 clk after the qualifying sample.
  - ALARM: mirror of NORMAL with qualify = sample <= TEMP_LO. Samples strictly between TEMP_LO and TEMP_HI clear cnt in both states (hysteresis band).
  - Cycles with temp_valid=0 hold cnt and state unchanged.
- Fuel FSM: same structure.
  - NORMAL to ALARM after DEBOUNCE consecutive valid samples with fuel_level <= FUEL_EMPTY.
  - ALARM to NORMAL after DEBOUNCE consecutive valid samples with fuel_level > FUEL_EMPTY.
  - gas_tank_empty = (state==ALARM).
- Counters saturate at DEBOUNCE and never wrap. Counter width is clog2(DEBOUNCE+1).
- Trip counter:
  - trip_load: dist_remaining<=trip_distance, and arrived<=(trip_distance==0).
  - wheel_tick with dist_remaining>0 and no trip_load: decrement. arrived<=1 on the edge where dist_remaining goes 1 to 0.
  - wheel_tick with dist_remaining==0: no change (no underflow, no wrap).
  - trip_load and wheel_tick in the same cycle: load wins and the tick is dropped.
- Reset mid-operation returns every output to its reset value immediately (async). The first qualifying sample after reset counts as 1.
- Simulation assertions: TEMP_LO < TEMP_HI and DEBOUNCE >= 1 at elaboration.

Decomposition:
- Package vehicle_status_pkg: typedef enum {ST_NORMAL, ST_ALARM} flag_state_t, plus a default-threshold localparam set.
- Sub-module hysteresis_debounce, instantiated twice (temp, fuel):
  - Inputs: clk, rst_n, valid, set_qual, clr_qual.
  - Parameters: DEBOUNCE and RESET_STATE.
  - Output: flag.
- The parent computes the qualify comparisons and holds the trip counter.

Test Plan:
- Reset release, no stimulus -> cpu_overheated=0, gas_tank_empty=1, arrived=1, dist_remaining=0.
- Temp samples 90,90,90,80,90,90,90,90 (all valid) -> flag stays 0 until 1 clk after the 8th sample. Sample 80 resets the count. Then 74 x4 -> flag clears 1 clk after the 4th.
- Temp 90,90, then temp_valid=0 for 10 cycles, then 90,90 -> flag sets. Gaps hold the count.
- Fuel 50 x4 -> empty 1 to 0. Then 3,3,3,50,3,3,3,3 -> empty=1 only after the final 4 lows.
- trip_load=1 with trip_distance=3, then 3 wheel_ticks -> arrived drops to 0, dist_remaining goes 3,2,1,0, arrived=1 on the 3rd tick. A 4th tick keeps 0/1. trip_load with trip_distance=0 -> arrived stays 1.
- trip_load with trip_distance=5 coincident with wheel_tick -> dist_remaining=5. Then rst_n pulse mid-trip -> all outputs at reset values immediately.

Source files
------------

// File: rtl/vehicle_status_pkg.sv
// Shared types and default thresholds for the vehicle status monitor.
// flag_state_t is the two-state hysteresis FSM encoding. The DEF_*
// localparams are the default widths and thresholds, used by both the
// RTL and the interface.
package vehicle_status_pkg;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_ALARM  = 1'b1
  } flag_state_t;

  localparam int unsigned DEF_TEMP_W     = 8;
  localparam int unsigned DEF_TEMP_HI    = 85;
  localparam int unsigned DEF_TEMP_LO    = 75;
  localparam int unsigned DEF_FUEL_W     = 8;
  localparam int unsigned DEF_FUEL_EMPTY = 4;
  localparam int unsigned DEF_DEBOUNCE   = 4;
  localparam int unsigned DEF_DIST_W     = 16;

endpackage

// File: rtl/vehicle_status_monitor_if.sv
// Sensor / status bundle of the vehicle status monitor.
//   master : sensor side. It drives the samples, trip load and wheel ticks,
//            and it reads the status flags.
//   slave  : monitor side. It reads the samples, and it drives the
//            registered flags and dist_remaining.
interface vehicle_status_monitor_if
  import vehicle_status_pkg::*;
#(
  parameter int unsigned TEMP_W = DEF_TEMP_W,
  parameter int unsigned FUEL_W = DEF_FUEL_W,
  parameter int unsigned DIST_W = DEF_DIST_W
);
  logic              temp_valid;
  logic [TEMP_W-1:0] temp_sample;
  logic              fuel_valid;
  logic [FUEL_W-1:0] fuel_level;
  logic              trip_load;
  logic [DIST_W-1:0] trip_distance;
  logic              wheel_tick;
  logic              cpu_overheated;
  logic              gas_tank_empty;
  logic              arrived;
  logic [DIST_W-1:0] dist_remaining;

  modport master (
    output temp_valid, temp_sample, fuel_valid, fuel_level,
           trip_load, trip_distance, wheel_tick,
    input  cpu_overheated, gas_tank_empty, arrived, dist_remaining
  );

  modport slave (
    input  temp_valid, temp_sample, fuel_valid, fuel_level,
           trip_load, trip_distance, wheel_tick,
    output cpu_overheated, gas_tank_empty, arrived, dist_remaining
  );
endinterface

// File: rtl/hysteresis_debounce.sv
// Two-state debounced hysteresis flag.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   valid      : a sample is present this cycle
//   set_qual   : the sample qualifies to move from NORMAL to ALARM
//   clr_qual   : the sample qualifies to move from ALARM to NORMAL
//   flag       : 1 while the FSM is in ALARM (taken directly from the state flop)
// The FSM changes state once DEBOUNCE consecutive valid samples qualify for
// the current state. A valid sample that does not qualify clears the count.
// Invalid cycles hold both the count and the state.
module hysteresis_debounce
  import vehicle_status_pkg::*;
#(
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE,
  parameter flag_state_t RESET_STATE = ST_NORMAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic set_qual,
  input  logic clr_qual,
  output logic flag
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);

  flag_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qual;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qual    = (state_q == ST_NORMAL) ? set_qual : clr_qual;
    if (valid) begin
      if (qual) begin
        // The sample that completes the run flips the state and restarts the count.
        if (cnt_q == CNT_LAST) begin
          state_d = (state_q == ST_NORMAL) ? ST_ALARM : ST_NORMAL;
          cnt_d   = '0;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flag = (state_q == ST_ALARM);

endmodule

// File: rtl/vehicle_status_monitor.sv
// Vehicle status monitor: converts raw sensor samples into registered,
// debounced status flags that the safety logic consumes.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of vehicle_status_monitor_if
//     temp_valid/temp_sample -> cpu_overheated (set at >= TEMP_HI, clear at <= TEMP_LO)
//     fuel_valid/fuel_level  -> gas_tank_empty (low when level <= FUEL_EMPTY)
//     trip_load/trip_distance/wheel_tick -> dist_remaining, arrived
// At reset: no overheat, tank reported empty, trip reported arrived.
module vehicle_status_monitor
  import vehicle_status_pkg::*;
#(
  parameter int unsigned TEMP_W     = DEF_TEMP_W,
  parameter int unsigned TEMP_HI    = DEF_TEMP_HI,
  parameter int unsigned TEMP_LO    = DEF_TEMP_LO,
  parameter int unsigned FUEL_W     = DEF_FUEL_W,
  parameter int unsigned FUEL_EMPTY = DEF_FUEL_EMPTY,
  parameter int unsigned DEBOUNCE   = DEF_DEBOUNCE,
  parameter int unsigned DIST_W     = DEF_DIST_W
) (
  input logic                     clk,
  input logic                     rst_n,
  vehicle_status_monitor_if.slave bus
);

  if (TEMP_LO >= TEMP_HI) begin : g_bad_temp_thresholds
    $error("vehicle_status_monitor: TEMP_LO must be below TEMP_HI");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("vehicle_status_monitor: DEBOUNCE must be at least 1");
  end

  localparam logic [TEMP_W-1:0] TEMP_HI_C    = TEMP_W'(TEMP_HI);
  localparam logic [TEMP_W-1:0] TEMP_LO_C    = TEMP_W'(TEMP_LO);
  localparam logic [FUEL_W-1:0] FUEL_EMPTY_C = FUEL_W'(FUEL_EMPTY);

  logic temp_set_qual, temp_clr_qual;
  logic fuel_set_qual, fuel_clr_qual;

  assign temp_set_qual = (bus.temp_sample >= TEMP_HI_C);
  assign temp_clr_qual = (bus.temp_sample <= TEMP_LO_C);
  assign fuel_set_qual = (bus.fuel_level <= FUEL_EMPTY_C);
  assign fuel_clr_qual = !fuel_set_qual;

  hysteresis_debounce #(
    .DEBOUNCE    (DEBOUNCE),
    .RESET_STATE (ST_NORMAL)
  ) u_temp_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (bus.temp_valid),
    .set_qual (temp_set_qual),
    .clr_qual (temp_clr_qual),
    .flag     (bus.cpu_overheated)
  );

  hysteresis_debounce #(
    .DEBOUNCE    (DEBOUNCE),
    .RESET_STATE (ST_ALARM)
  ) u_fuel_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (bus.fuel_valid),
    .set_qual (fuel_set_qual),
    .clr_qual (fuel_clr_qual),
    .flag     (bus.gas_tank_empty)
  );

  logic [DIST_W-1:0] dist_q, dist_d;
  logic              arrived_q, arrived_d;

  // When a load and a tick arrive together, the load takes priority and the tick is dropped.
  always_comb begin
    dist_d    = dist_q;
    arrived_d = arrived_q;
    if (bus.trip_load) begin
      dist_d    = bus.trip_distance;
      arrived_d = (bus.trip_distance == '0);
    end else if (bus.wheel_tick && (dist_q != '0)) begin
      dist_d = dist_q - 1'b1;
      if (dist_q == DIST_W'(1)) begin
        arrived_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_q    <= '0;
      arrived_q <= 1'b1;
    end else begin
      dist_q    <= dist_d;
      arrived_q <= arrived_d;
    end
  end

  assign bus.dist_remaining = dist_q;
  assign bus.arrived        = arrived_q;

endmodule

// File: tb/tb_vehicle_status_monitor.sv
module tb_vehicle_status_monitor;
  import vehicle_status_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  vehicle_status_monitor_if #(.TEMP_W(8), .FUEL_W(8), .DIST_W(16)) bus ();

  vehicle_status_monitor #(
    .TEMP_W(8), .TEMP_HI(85), .TEMP_LO(75), .FUEL_W(8),
    .FUEL_EMPTY(4), .DEBOUNCE(4), .DIST_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Each step task applies one cycle of stimulus. It starts 1 time unit after a
  // rising edge and returns 1 time unit after the next rising edge.
  task automatic temp_step(input logic v, input logic [7:0] s);
    bus.temp_valid  = v;
    bus.temp_sample = s;
    @(posedge clk); #1;
    bus.temp_valid  = 1'b0;
  endtask

  task automatic fuel_step(input logic [7:0] l);
    bus.fuel_valid = 1'b1;
    bus.fuel_level = l;
    @(posedge clk); #1;
    bus.fuel_valid = 1'b0;
  endtask

  task automatic trip_step(input logic ld, input logic [15:0] d, input logic tk);
    bus.trip_load     = ld;
    bus.trip_distance = d;
    bus.wheel_tick    = tk;
    @(posedge clk); #1;
    bus.trip_load  = 1'b0;
    bus.wheel_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.cpu_overheated !== 1'b0) begin fails++; $display("FAIL reset_overheat got=%b exp=0", bus.cpu_overheated); end
    tests++; if (bus.gas_tank_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", bus.gas_tank_empty); end
    tests++; if (bus.arrived !== 1'b1) begin fails++; $display("FAIL reset_arrived got=%b exp=1", bus.arrived); end
    tests++; if (bus.dist_remaining !== 16'd0) begin fails++; $display("FAIL reset_dist got=%0d exp=0", bus.dist_remaining); end
  endtask

  task automatic test_temp_hysteresis();
    logic [7:0] seq [8] = '{8'd90, 8'd90, 8'd90, 8'd80, 8'd90, 8'd90, 8'd90, 8'd90};
    logic       exp;
    for (int i = 0; i < 8; i++) begin
      temp_step(1'b1, seq[i]);
      exp = (i == 7);
      tests++;
      if (bus.cpu_overheated !== exp) begin
        fails++; $display("FAIL temp_set[%0d] got=%b exp=%b", i, bus.cpu_overheated, exp);
      end
    end
    // A sample inside the hysteresis band restarts the clear count.
    temp_step(1'b1, 8'd74);
    temp_step(1'b1, 8'd80);
    tests++; if (bus.cpu_overheated !== 1'b1) begin fails++; $display("FAIL temp_band got=%b exp=1", bus.cpu_overheated); end
    for (int i = 0; i < 4; i++) begin
      temp_step(1'b1, 8'd74);
      exp = (i != 3);
      tests++;
      if (bus.cpu_overheated !== exp) begin
        fails++; $display("FAIL temp_clear[%0d] got=%b exp=%b", i, bus.cpu_overheated, exp);
      end
    end
  endtask

  task automatic test_temp_gaps();
    temp_step(1'b1, 8'd90);
    temp_step(1'b1, 8'd90);
    for (int i = 0; i < 10; i++) begin
      temp_step(1'b0, 8'd0);
      tests++;
      if (bus.cpu_overheated !== 1'b0) begin
        fails++; $display("FAIL temp_gap[%0d] got=%b exp=0", i, bus.cpu_overheated);
      end
    end
    temp_step(1'b1, 8'd90);
    tests++; if (bus.cpu_overheated !== 1'b0) begin fails++; $display("FAIL temp_gap_3rd got=%b exp=0", bus.cpu_overheated); end
    temp_step(1'b1, 8'd85);
    tests++; if (bus.cpu_overheated !== 1'b1) begin fails++; $display("FAIL temp_gap_4th got=%b exp=1", bus.cpu_overheated); end
    repeat (3) temp_step(1'b1, 8'd75);
    temp_step(1'b1, 8'd75);
    tests++; if (bus.cpu_overheated !== 1'b0) begin fails++; $display("FAIL temp_cool_at_lo got=%b exp=0", bus.cpu_overheated); end
  endtask

  task automatic test_fuel();
    logic [7:0] seq [8] = '{8'd3, 8'd3, 8'd3, 8'd50, 8'd3, 8'd3, 8'd3, 8'd4};
    logic       exp;
    for (int i = 0; i < 4; i++) begin
      fuel_step(8'd50);
      exp = (i != 3);
      tests++;
      if (bus.gas_tank_empty !== exp) begin
        fails++; $display("FAIL fuel_fill[%0d] got=%b exp=%b", i, bus.gas_tank_empty, exp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      fuel_step(seq[i]);
      exp = (i == 7);
      tests++;
      if (bus.gas_tank_empty !== exp) begin
        fails++; $display("FAIL fuel_drain[%0d] got=%b exp=%b", i, bus.gas_tank_empty, exp);
      end
    end
  endtask

  task automatic test_trip();
    logic [15:0] exp_d;
    trip_step(1'b1, 16'd3, 1'b0);
    tests++; if (bus.dist_remaining !== 16'd3 || bus.arrived !== 1'b0) begin
      fails++; $display("FAIL trip_load3 got=%0d/%b exp=3/0", bus.dist_remaining, bus.arrived);
    end
    for (int i = 0; i < 4; i++) begin
      trip_step(1'b0, 16'd0, 1'b1);
      exp_d = (i < 3) ? 16'(2 - i) : 16'd0;
      tests++;
      if (bus.dist_remaining !== exp_d || bus.arrived !== (i >= 2)) begin
        fails++; $display("FAIL trip_tick[%0d] got=%0d/%b exp=%0d/%b", i, bus.dist_remaining, bus.arrived, exp_d, (i >= 2));
      end
    end
    trip_step(1'b1, 16'd0, 1'b0);
    tests++; if (bus.dist_remaining !== 16'd0 || bus.arrived !== 1'b1) begin
      fails++; $display("FAIL trip_load0 got=%0d/%b exp=0/1", bus.dist_remaining, bus.arrived);
    end
  endtask

  task automatic test_back_to_back();
    trip_step(1'b1, 16'd5, 1'b1);
    tests++; if (bus.dist_remaining !== 16'd5 || bus.arrived !== 1'b0) begin
      fails++; $display("FAIL load_tick_collide got=%0d/%b exp=5/0", bus.dist_remaining, bus.arrived);
    end
    trip_step(1'b0, 16'd0, 1'b1);
    tests++; if (bus.dist_remaining !== 16'd4) begin
      fails++; $display("FAIL tick_after_load got=%0d exp=4", bus.dist_remaining);
    end
    repeat (4) temp_step(1'b1, 8'd100);
    repeat (4) fuel_step(8'd200);
    tests++; if (bus.cpu_overheated !== 1'b1 || bus.gas_tank_empty !== 1'b0) begin
      fails++; $display("FAIL pre_reset_flags got=%b/%b exp=1/0", bus.cpu_overheated, bus.gas_tank_empty);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.cpu_overheated !== 1'b0 || bus.gas_tank_empty !== 1'b1 ||
                 bus.arrived !== 1'b1 || bus.dist_remaining !== 16'd0) begin
      fails++; $display("FAIL async_reset got=%b/%b/%b/%0d exp=0/1/1/0",
                        bus.cpu_overheated, bus.gas_tank_empty, bus.arrived, bus.dist_remaining);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      temp_step(1'b1, 8'd90);
      tests++;
      if (bus.cpu_overheated !== (i == 3)) begin
        fails++; $display("FAIL post_reset_temp[%0d] got=%b exp=%b", i, bus.cpu_overheated, (i == 3));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.temp_valid    = 1'b0;
    bus.temp_sample   = '0;
    bus.fuel_valid    = 1'b0;
    bus.fuel_level    = '0;
    bus.trip_load     = 1'b0;
    bus.trip_distance = '0;
    bus.wheel_tick    = 1'b0;
    test_reset();
    test_temp_hysteresis();
    test_temp_gaps();
    test_fuel();
    test_trip();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
